// File: rtl/hist_pkg.sv
// Histogram engine shared types.
// State encoding and default geometry.
package hist_pkg;

  localparam int DEF_BIN_BITS    = 7;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_STORE,
    ST_DRAIN,
    ST_READ
  } state_e;

endpackage

// File: rtl/histogram_ram.sv
// Simple dual-port bin memory.
// One write port, one synchronous read port.
module histogram_ram #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/histogram_engine.sv
// Histogram engine: bins samples into a RAM,
// then streams all bins out with valid/ready.
module histogram_engine
  import hist_pkg::*;
#(
  parameter int BIN_BITS      = DEF_BIN_BITS,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [BIN_BITS-1:0]    sample_value,
  output logic                   sample_ready,
  input  logic                   start_readout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_BITS-1:0]    out_bin,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_last,
  output logic                   busy,
  output logic [31:0]            total_samples
);

  localparam int NBINS = 2**BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NBINS-1);
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  typedef logic [BIN_BITS-1:0]    bin_t;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  state_e        state_q, state_d;
  bin_t          clr_q, clr_d;
  logic          s1_vld_q, s1_vld_d;
  bin_t          s1_bin_q, s1_bin_d;
  logic          fw_vld_q, fw_vld_d;
  bin_t          fw_bin_q, fw_bin_d;
  cnt_t          fw_cnt_q, fw_cnt_d;
  logic [31:0]   tot_q, tot_d;
  logic [BIN_BITS:0] rd_ptr_q, rd_ptr_d;
  logic          rd_pend_q, rd_pend_d;
  bin_t          rd_pbin_q, rd_pbin_d;
  logic [1:0]    sk_n_q, sk_n_d;
  bin_t          h_bin_q, h_bin_d, t_bin_q, t_bin_d;
  cnt_t          h_cnt_q, h_cnt_d, t_cnt_q, t_cnt_d;

  logic          accept, pop, issue;
  logic [2:0]    occ;
  logic [1:0]    c1;
  cnt_t          base, inc;
  logic          we;
  bin_t          waddr, raddr;
  cnt_t          wdata, rdata;

  histogram_ram #(
    .AW (BIN_BITS),
    .DW (COUNT_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Increment datapath with forwarding and the RAM port muxes.
  always_comb begin
    accept = (state_q == ST_STORE) && sample_valid;
    base = (fw_vld_q && (fw_bin_q == s1_bin_q)) ? fw_cnt_q : rdata;
    inc = (base == CMAX) ? base : base + 1'b1;
    pop = (sk_n_q != 2'd0) && out_ready;
    occ = {1'b0, sk_n_q} + {2'b0, rd_pend_q} - {2'b0, pop};
    issue = (state_q == ST_READ) && !rd_ptr_q[BIN_BITS]
            && (occ < 3'd2);
    we = 1'b0;
    waddr = s1_bin_q;
    wdata = inc;
    raddr = sample_value;
    if (state_q == ST_CLEAR) begin
      we = 1'b1;
      waddr = clr_q;
      wdata = '0;
    end else if (s1_vld_q) begin
      we = 1'b1;
    end
    if (state_q == ST_READ) raddr = rd_ptr_q[BIN_BITS-1:0];
  end

  // Next state, pipeline, readout pointer and skid buffer.
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    s1_vld_d = accept;
    s1_bin_d = sample_value;
    fw_vld_d = s1_vld_q;
    fw_bin_d = s1_bin_q;
    fw_cnt_d = inc;
    tot_d = tot_q;
    rd_ptr_d = rd_ptr_q;
    rd_pend_d = issue;
    rd_pbin_d = rd_ptr_q[BIN_BITS-1:0];
    h_bin_d = h_bin_q;
    h_cnt_d = h_cnt_q;
    t_bin_d = t_bin_q;
    t_cnt_d = t_cnt_q;
    if (accept && (tot_q != 32'hFFFF_FFFF)) tot_d = tot_q + 32'd1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (state_q)
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_BIN) state_d = ST_STORE;
      end
      ST_STORE: begin
        if (start_readout) state_d = ST_DRAIN;
      end
      // The last increment writes this cycle, so READ sees it.
      ST_DRAIN: begin
        state_d = ST_READ;
        rd_ptr_d = '0;
      end
      ST_READ: begin
        if (pop && (h_bin_q == LAST_BIN)) begin
          if (CLEAR_ON_READ != 0) begin
            state_d = ST_CLEAR;
            clr_d = '0;
            tot_d = '0;
          end else begin
            state_d = ST_STORE;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    c1 = sk_n_q - {1'b0, pop};
    if (pop) begin
      h_bin_d = t_bin_q;
      h_cnt_d = t_cnt_q;
    end
    if (rd_pend_q) begin
      if (c1 == 2'd0) begin
        h_bin_d = rd_pbin_q;
        h_cnt_d = rdata;
      end else begin
        t_bin_d = rd_pbin_q;
        t_cnt_d = rdata;
      end
    end
    sk_n_d = c1 + {1'b0, rd_pend_q};
  end

  // State registers; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q <= '0;
      s1_vld_q <= 1'b0;
      s1_bin_q <= '0;
      fw_vld_q <= 1'b0;
      fw_bin_q <= '0;
      fw_cnt_q <= '0;
      tot_q <= '0;
      rd_ptr_q <= '0;
      rd_pend_q <= 1'b0;
      rd_pbin_q <= '0;
      sk_n_q <= '0;
      h_bin_q <= '0;
      h_cnt_q <= '0;
      t_bin_q <= '0;
      t_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      s1_vld_q <= s1_vld_d;
      s1_bin_q <= s1_bin_d;
      fw_vld_q <= fw_vld_d;
      fw_bin_q <= fw_bin_d;
      fw_cnt_q <= fw_cnt_d;
      tot_q <= tot_d;
      rd_ptr_q <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_pbin_q <= rd_pbin_d;
      sk_n_q <= sk_n_d;
      h_bin_q <= h_bin_d;
      h_cnt_q <= h_cnt_d;
      t_bin_q <= t_bin_d;
      t_cnt_q <= t_cnt_d;
    end
  end

  assign sample_ready  = (state_q == ST_STORE);
  assign busy          = (state_q != ST_STORE);
  assign out_valid     = (sk_n_q != 2'd0);
  assign out_bin       = h_bin_q;
  assign out_count     = h_cnt_q;
  assign out_last      = out_valid && (h_bin_q == LAST_BIN);
  assign total_samples = tot_q;

endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: three instances
// (default, 4-bit counters, keep-on-read) vs a bin model.
module tb_histogram_engine;

  logic clk = 1'b0;
  logic reset, sample_valid, start_readout, out_ready;
  logic [6:0] sample_value;
  logic [2:0] sr, ov, ol, bz;
  logic [2:0][6:0] ob;
  logic [2:0][31:0] ts;
  logic [15:0] oc0, oc2;
  logic [3:0] oc1;
  logic [15:0] oc [3];

  always #5 clk = ~clk;

  always_comb begin
    oc[0] = oc0;
    oc[1] = {12'd0, oc1};
    oc[2] = oc2;
  end

  histogram_engine u_dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_value(sample_value),
    .sample_ready(sr[0]), .start_readout(start_readout),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_bin(ob[0]), .out_count(oc0), .out_last(ol[0]),
    .busy(bz[0]), .total_samples(ts[0])
  );

  histogram_engine #(.COUNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_value(sample_value),
    .sample_ready(sr[1]), .start_readout(start_readout),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_bin(ob[1]), .out_count(oc1), .out_last(ol[1]),
    .busy(bz[1]), .total_samples(ts[1])
  );

  histogram_engine #(.CLEAR_ON_READ(0)) u_keep (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_value(sample_value),
    .sample_ready(sr[2]), .start_readout(start_readout),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_bin(ob[2]), .out_count(oc2), .out_last(ol[2]),
    .busy(bz[2]), .total_samples(ts[2])
  );

  int checks = 0;
  int failures = 0;
  int cyc_i = 0;
  bit noise = 0;

  longint unsigned mdl [3][128];
  longint unsigned tot [3];
  longint unsigned maxv [3] = '{65535, 15, 65535};
  int nxt [3];
  int first [3];
  int lastc [3];
  bit [2:0] done;
  bit [2:0] stall;
  longint unsigned sb [3];
  longint unsigned sc [3];
  longint unsigned cap7;

  task automatic chk(string tag, longint unsigned got, longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_model(int i);
    for (int b = 0; b < 128; b++) mdl[i][b] = 0;
    tot[i] = 0;
  endtask

  task automatic rnd_sample();
    if (noise) begin
      sample_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        sample_value = 7'($urandom_range(0, 127));
      else
        sample_value = 7'($urandom_range(0, 7));
    end else begin
      sample_valid = 1'b0;
    end
  endtask

  // Apply model effects of the handshakes at the coming edge, then advance.
  task automatic tick();
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (sample_valid && sr[i]) begin
          if (mdl[i][sample_value] < maxv[i]) mdl[i][sample_value]++;
          if (tot[i] < 64'hFFFF_FFFF) tot[i]++;
        end
        if (stall[i]) begin
          chk("hold_valid", ov[i], 1);
          chk("hold_bin", ob[i], sb[i]);
          chk("hold_cnt", oc[i], sc[i]);
        end
        stall[i] = ov[i] && !out_ready;
        sb[i] = ob[i];
        sc[i] = oc[i];
        if (ov[i] && out_ready && nxt[i] < 128) begin
          chk("rd_bin", ob[i], nxt[i]);
          chk("rd_cnt", oc[i], mdl[i][nxt[i]]);
          chk("rd_last", ol[i], nxt[i] == 127);
          if (i == 2 && nxt[i] == 7) cap7 = oc[i];
          if (nxt[i] == 0) first[i] = cyc_i;
          if (nxt[i] == 127) begin
            done[i] = 1'b1;
            lastc[i] = cyc_i;
            if (i < 2) clear_model(i);
          end
          nxt[i]++;
        end else if (ov[i] && out_ready) begin
          chk("extra_word", 1, 0);
        end
      end
    end
    cyc_i++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit chkv);
    int n;
    reset = 1'b1;
    sample_valid = 1'b0;
    start_readout = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    if (chkv) begin
      chk("rst_ready", sr, 0);
      chk("rst_valid", ov, 0);
      chk("rst_last", ol, 0);
      chk("rst_bin", ob, 0);
      chk("rst_cnt", oc[0], 0);
      chk("rst_busy", bz, 3'b111);
      chk("rst_total", ts[0], 0);
    end
    for (int i = 0; i < 3; i++) clear_model(i);
    stall = '0;
    done = '1;
    reset = 1'b0;
    n = 0;
    while (!sr[0] && n < 1000) begin
      rnd_sample();
      tick();
      n++;
    end
    sample_valid = 1'b0;
    chk("ready_lat", n, 128);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(&sr) && n < 2000) begin
      rnd_sample();
      tick();
      n++;
    end
    sample_valid = 1'b0;
    chk("ready_wait", &sr, 1);
  endtask

  task automatic readout(bit rnd, int abort_at);
    int s_cyc, k;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      nxt[i] = 0;
      first[i] = -1;
    end
    done = '0;
    start_readout = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    sample_valid = noise;
    sample_value = 7'($urandom_range(0, 127));
    s_cyc = cyc_i;
    tick();
    start_readout = 1'b0;
    chk("busy_rd", bz, 3'b111);
    k = 0;
    while (!(&done) && k < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rnd_sample();
      if (abort_at >= 0 && nxt[0] == abort_at) begin
        do_reset(0);
        return;
      end
      tick();
      k++;
    end
    out_ready = 1'b0;
    sample_valid = 1'b0;
    chk("rd_done", done, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk("rd_words", nxt[i], 128);
      chk("first_lat", (first[i] - s_cyc) <= 5, 1);
      if (!rnd) chk("tput", lastc[i] - first[i], 127);
      chk("total", ts[i], tot[i]);
    end
  endtask

  task automatic feed(int v, int n);
    for (int j = 0; j < n; j++) begin
      sample_valid = 1'b1;
      sample_value = 7'(v);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_value = '0;
    start_readout = 1'b0;
    out_ready = 1'b0;
    stall = '0;
    done = '1;
    cap7 = 0;
    do_reset(1);

    readout(0, -1);

    wait_ready();
    feed(5, 3);
    feed(9, 1);
    tick();
    chk("tot_5559", ts[0], 4);
    readout(0, -1);

    wait_ready();
    feed(3, 20);
    tick();
    chk("tot_sat", ts[1], 20);
    readout(0, -1);

    noise = 1;
    for (int r = 0; r < 2; r++) begin
      wait_ready();
      for (int j = 0; j < 300; j++) begin
        rnd_sample();
        tick();
      end
      readout(1, -1);
    end

    noise = 0;
    do_reset(0);
    feed(7, 2);
    readout(0, -1);
    chk("keep_bin7_a", cap7, 2);
    feed(7, 1);
    readout(0, -1);
    chk("keep_bin7_b", cap7, 3);

    noise = 1;
    wait_ready();
    for (int j = 0; j < 200; j++) begin
      rnd_sample();
      tick();
    end
    readout(1, 40);
    chk("abort_total", ts[2], 0);
    noise = 0;
    readout(0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
